wash_phase_timer: RTL and testbench



---
 rtl/wash_phase_timer.sv | 151 +++++++++++++++
 tb/tb_wash_phase_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: per-phase duration timer for the washing-machine controller.
// Tracks the controller's current_state, times each active phase with a prescaled
// tick counter and emits the one-hot DoneFlags pulse that advances the controller.
// Optional watchdog (sticky Fault) is built only when WASH_TIMER_WATCHDOG_EN is defined.
module wash_phase_timer #(
    parameter int unsigned TICK_DIV    = 60,
    parameter int unsigned FILL_TICKS  = 2,
    parameter int unsigned WASH_TICKS  = 5,
    parameter int unsigned RINSE_TICKS = 2,
    parameter int unsigned SPIN_TICKS  = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       current_state,
    input  logic             Pause,
    output logic [3:0]       DoneFlags,
    output logic [CNT_W-1:0] Remaining,
    output logic             Busy,
    output logic             Fault
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;

    // Durations are truncated to the counter width; a zero duration runs as one tick.
    localparam logic [CNT_W-1:0] FILL_T  = CNT_W'(FILL_TICKS);
    localparam logic [CNT_W-1:0] WASH_T  = CNT_W'(WASH_TICKS);
    localparam logic [CNT_W-1:0] RINSE_T = CNT_W'(RINSE_TICKS);
    localparam logic [CNT_W-1:0] SPIN_T  = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0] DUR_FILL  = (FILL_T  == '0) ? CNT_W'(1) : FILL_T;
    localparam logic [CNT_W-1:0] DUR_WASH  = (WASH_T  == '0) ? CNT_W'(1) : WASH_T;
    localparam logic [CNT_W-1:0] DUR_RINSE = (RINSE_T == '0) ? CNT_W'(1) : RINSE_T;
    localparam logic [CNT_W-1:0] DUR_SPIN  = (SPIN_T  == '0) ? CNT_W'(1) : SPIN_T;

    logic [2:0]       r_latched;
    logic [PRE_W-1:0] r_prescaler;
    logic [CNT_W-1:0] r_ticks;
    logic             r_expired;

    logic             w_active;
    logic [CNT_W-1:0] w_dur;
    logic [3:0]       w_bit;
    logic             w_new_active;
    logic [CNT_W-1:0] w_new_dur;
    logic             w_entry;
    logic             w_count_en;
    logic             w_tick;
    logic             w_last;

    // Decode the latched phase and the incoming phase into duration / done bit.
    always_comb begin
        w_active     = 1'b0;
        w_dur        = '0;
        w_bit        = 4'b0000;
        w_new_active = 1'b0;
        w_new_dur    = '0;
        case (r_latched)
            PH_FILL:  begin w_active = 1'b1; w_dur = DUR_FILL;  w_bit = 4'b1000; end
            PH_WASH:  begin w_active = 1'b1; w_dur = DUR_WASH;  w_bit = 4'b0100; end
            PH_RINSE: begin w_active = 1'b1; w_dur = DUR_RINSE; w_bit = 4'b0010; end
            PH_SPIN:  begin w_active = 1'b1; w_dur = DUR_SPIN;  w_bit = 4'b0001; end
            default:  ;
        endcase
        case (current_state)
            PH_FILL:  begin w_new_active = 1'b1; w_new_dur = DUR_FILL;  end
            PH_WASH:  begin w_new_active = 1'b1; w_new_dur = DUR_WASH;  end
            PH_RINSE: begin w_new_active = 1'b1; w_new_dur = DUR_RINSE; end
            PH_SPIN:  begin w_new_active = 1'b1; w_new_dur = DUR_SPIN;  end
            default:  ;
        endcase
    end

    assign w_entry    = (current_state != r_latched);
    assign w_count_en = w_active && !Pause && !r_expired && !w_entry;
    assign w_tick     = w_count_en && (r_prescaler == PRE_LAST);
    assign w_last     = w_tick && (r_ticks == (w_dur - CNT_W'(1)));

    // Phase entry, prescaled tick counting and the single-cycle done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_latched   <= PH_IDLE;
            r_prescaler <= '0;
            r_ticks     <= '0;
            r_expired   <= 1'b0;
            DoneFlags   <= 4'b0000;
            Remaining   <= '0;
            Busy        <= 1'b0;
        end else begin
            DoneFlags <= 4'b0000;
            if (w_entry) begin
                r_latched   <= current_state;
                r_prescaler <= '0;
                r_ticks     <= '0;
                r_expired   <= 1'b0;
                Remaining   <= w_new_dur;
                Busy        <= w_new_active;
            end else if (w_count_en) begin
                if (w_tick) begin
                    r_prescaler <= '0;
                    r_ticks     <= r_ticks + CNT_W'(1);
                    Remaining   <= w_dur - r_ticks - CNT_W'(1);
                    if (w_last) begin
                        DoneFlags <= w_bit;
                        r_expired <= 1'b1;
                        Busy      <= 1'b0;
                    end
                end else begin
                    r_prescaler <= r_prescaler + PRE_W'(1);
                end
            end else if (!w_active) begin
                r_prescaler <= '0;
                r_ticks     <= '0;
                Remaining   <= '0;
                Busy        <= 1'b0;
            end
        end
    end

`ifdef WASH_TIMER_WATCHDOG_EN
    logic [1:0] r_wd_cnt;
    logic       r_fault;

    // Count cycles spent in an expired phase; flag a stuck controller after four.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wd_cnt <= 2'd0;
            r_fault  <= 1'b0;
        end else if (w_entry) begin
            r_wd_cnt <= 2'd0;
        end else if (r_expired) begin
            if (r_wd_cnt == 2'd3) begin
                r_fault <= 1'b1;
            end else begin
                r_wd_cnt <= r_wd_cnt + 2'd1;
            end
        end
    end

    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed testbench for wash_phase_timer (TICK_DIV=4, FILL=2, WASH=3, RINSE=2, SPIN=1).
module tb_wash_phase_timer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] cs;
    logic       Pause;
    logic [3:0] DoneFlags;
    logic [7:0] Remaining;
    logic       Busy;
    logic       Fault;

    int checks = 0;
    int errors = 0;

`ifdef WASH_TIMER_WATCHDOG_EN
    localparam logic FEXP = 1'b1;
`else
    localparam logic FEXP = 1'b0;
`endif

    wash_phase_timer #(
        .TICK_DIV(4), .FILL_TICKS(2), .WASH_TICKS(3),
        .RINSE_TICKS(2), .SPIN_TICKS(1), .CNT_W(8)
    ) dut (
        .CLK(CLK), .RST(RST), .current_state(cs), .Pause(Pause),
        .DoneFlags(DoneFlags), .Remaining(Remaining), .Busy(Busy), .Fault(Fault)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; cs = 3'd0; Pause = 1'b0;
        step(); step();
        checks++; if (DoneFlags !== 4'b0000) begin errors++; $display("FAIL reset_done got %b exp 0000", DoneFlags); end
        checks++; if (Remaining !== 8'd0) begin errors++; $display("FAIL reset_rem got %0d exp 0", Remaining); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", Fault); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_fill;
        logic [3:0] exp_d;
        logic [7:0] exp_r;
        cs = 3'd1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_d = (k == 9) ? 4'b1000 : 4'b0000;
            exp_r = (k < 5) ? 8'd2 : ((k < 9) ? 8'd1 : 8'd0);
            checks++; if (DoneFlags !== exp_d) begin errors++; $display("FAIL fill_done step %0d got %b exp %b", k, DoneFlags, exp_d); end
            checks++; if (Remaining !== exp_r) begin errors++; $display("FAIL fill_rem step %0d got %0d exp %0d", k, Remaining, exp_r); end
            checks++; if (Busy !== (k < 9)) begin errors++; $display("FAIL fill_busy step %0d got %b exp %b", k, Busy, (k < 9)); end
        end
        step();
        checks++; if (DoneFlags !== 4'b0000) begin errors++; $display("FAIL fill_pulse_width got %b exp 0000", DoneFlags); end
        cs = 3'd0;
        step(); step();
    endtask

    task automatic test_full_cycle;
        int         durs[4] = '{2, 3, 2, 1};
        logic [3:0] bits[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic [3:0] exp_d;
        logic [7:0] exp_r;
        int         t;
        for (int p = 0; p < 4; p++) begin
            cs = 3'(p + 1);
            t = 4 * durs[p] + 1;
            for (int k = 1; k <= t; k++) begin
                step();
                exp_d = (k == t) ? bits[p] : 4'b0000;
                exp_r = 8'(durs[p] - (k - 1) / 4);
                checks++; if (DoneFlags !== exp_d) begin errors++; $display("FAIL cycle_done ph %0d step %0d got %b exp %b", p + 1, k, DoneFlags, exp_d); end
                checks++; if (Remaining !== exp_r) begin errors++; $display("FAIL cycle_rem ph %0d step %0d got %0d exp %0d", p + 1, k, Remaining, exp_r); end
                checks++; if (Busy !== (k < t)) begin errors++; $display("FAIL cycle_busy ph %0d step %0d got %b exp %b", p + 1, k, Busy, (k < t)); end
            end
            step();
            checks++; if (DoneFlags !== 4'b0000) begin errors++; $display("FAIL cycle_after ph %0d got %b exp 0000", p + 1, DoneFlags); end
        end
        cs = 3'd0;
        step(); step();
        checks++; if (DoneFlags !== 4'b0000) begin errors++; $display("FAIL idle_done got %b exp 0000", DoneFlags); end
        checks++; if (Remaining !== 8'd0) begin errors++; $display("FAIL idle_rem got %0d exp 0", Remaining); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", Busy); end
    endtask

    task automatic test_pause;
        logic [3:0] exp_d;
        cs = 3'd2;
        for (int k = 1; k <= 19; k++) begin
            Pause = (k >= 5 && k <= 10);
            step();
            exp_d = (k == 19) ? 4'b0100 : 4'b0000;
            checks++; if (DoneFlags !== exp_d) begin errors++; $display("FAIL pause_done step %0d got %b exp %b", k, DoneFlags, exp_d); end
            if (k == 10) begin
                checks++; if (Remaining !== 8'd3) begin errors++; $display("FAIL pause_hold_rem got %0d exp 3", Remaining); end
                checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL pause_busy got %b exp 1", Busy); end
            end
            if (k == 11) begin
                checks++; if (Remaining !== 8'd2) begin errors++; $display("FAIL pause_tick_kept got %0d exp 2", Remaining); end
            end
        end
        Pause = 1'b0;
        step();
        cs = 3'd0;
        step(); step();
    endtask

    task automatic test_double_wash;
        logic [3:0] exp_d;
        cs = 3'd2;
        repeat (14) step();
        cs = 3'd3;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_d = (k == 9) ? 4'b0010 : 4'b0000;
            checks++; if (DoneFlags !== exp_d) begin errors++; $display("FAIL dw_rinse step %0d got %b exp %b", k, DoneFlags, exp_d); end
        end
        step();
        cs = 3'd2;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_d = (k == 13) ? 4'b0100 : 4'b0000;
            checks++; if (DoneFlags !== exp_d) begin errors++; $display("FAIL dw_wash step %0d got %b exp %b", k, DoneFlags, exp_d); end
            if (k == 1) begin
                checks++; if (Remaining !== 8'd3) begin errors++; $display("FAIL dw_reload got %0d exp 3", Remaining); end
                checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL dw_busy got %b exp 1", Busy); end
            end
        end
        step();
        cs = 3'd0;
        step(); step();
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_d;
        cs = 3'd2;
        repeat (6) step();
        RST = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (DoneFlags !== 4'b0000) begin errors++; $display("FAIL rst_mid_done step %0d got %b exp 0000", k, DoneFlags); end
            checks++; if (Remaining !== 8'd0) begin errors++; $display("FAIL rst_mid_rem step %0d got %0d exp 0", k, Remaining); end
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy step %0d got %b exp 0", k, Busy); end
        end
        RST = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_d = (k == 13) ? 4'b0100 : 4'b0000;
            checks++; if (DoneFlags !== exp_d) begin errors++; $display("FAIL rst_mid_recount step %0d got %b exp %b", k, DoneFlags, exp_d); end
        end
        step();
        cs = 3'd0;
        step(); step();
    endtask

    task automatic test_watchdog;
        logic exp_f;
        RST = 1'b1; cs = 3'd0;
        step();
        RST = 1'b0; cs = 3'd1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 9) begin
                checks++; if (DoneFlags !== 4'b1000) begin errors++; $display("FAIL wd_pulse got %b exp 1000", DoneFlags); end
            end
            if (k >= 9) begin
                exp_f = (k >= 13) ? FEXP : 1'b0;
                checks++; if (Fault !== exp_f) begin errors++; $display("FAIL wd_fault step %0d got %b exp %b", k, Fault, exp_f); end
            end
        end
        RST = 1'b1;
        step();
        checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp 0", Fault); end
        RST = 1'b0; cs = 3'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_cycle();
        test_pause();
        test_double_wash();
        test_reset_mid();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
